// File: rtl/part_2_fringe_sched.sv
// part_2_fringe_sched: shares one fringe channel among N_DOM mission-clock domains (put, then get, per edge).
// Latency: mission edge at T -> xfer_req_o at T+2 when idle; accepted response -> rx_valid_o pulse next cycle.
// Backpressure: request and payload held until xfer_ack_i; the WAIT phase is bounded by the WDOG_MAX watchdog.
// Option PART2_SCHED_ROUND_ROBIN_EN: round-robin grant; otherwise fixed priority (lowest index wins).
module part_2_fringe_sched #(
    parameter int N_DOM    = 4,
    parameter int DW       = 9,
    parameter int WDOG_MAX = 10000
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [N_DOM-1:0]    dom_clk_i,
    input  logic [N_DOM-1:0]    dom_en_i,
    input  logic [N_DOM-1:0]    put_en_i,
    input  logic [N_DOM-1:0]    get_en_i,
    input  logic [N_DOM*DW-1:0] tx_data_i,
    output logic                xfer_req_o,
    output logic                xfer_put_o,
    output logic [2:0]          xfer_dom_o,
    output logic [DW-1:0]       xfer_data_o,
    input  logic                xfer_ack_i,
    input  logic                rsp_valid_i,
    input  logic [2:0]          rsp_dom_i,
    input  logic [DW-1:0]       rsp_data_i,
    output logic [N_DOM-1:0]    rx_valid_o,
    output logic [N_DOM*DW-1:0] rx_data_o,
    output logic [N_DOM-1:0]    freeze_clk_o,
    output logic [N_DOM-1:0]    overrun_o,
    output logic                wdog_err_o,
    output logic                busy_o
);
    localparam int CW = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_PUT, S_GET, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [N_DOM-1:0]    dom_clk_d_q;
    logic [N_DOM-1:0]    pend_q, pend_d;
    logic [N_DOM-1:0]    ovr_q, ovr_d;
    logic [N_DOM-1:0]    frz_q, frz_d;
    logic [N_DOM-1:0]    rxv_q, rxv_d;
    logic [N_DOM*DW-1:0] rx_q, rx_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic [2:0]          g_q, g_d;
    logic                put_q, put_d;
    logic                get_q, get_d;
    logic                wdog_q, wdog_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [N_DOM-1:0]    edg;
    logic [N_DOM-1:0]    gnt_oh;
    logic [N_DOM-1:0]    g_oh;
    logic                gnt_vld;
    logic [2:0]          gnt_idx;
    logic                acc;
    logic                tmo;
`ifdef PART2_SCHED_ROUND_ROBIN_EN
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          hi_idx, lo_idx;
    logic                hi_vld;
`endif

    // Grant selection among pending domains, only meaningful while idle.
    always_comb begin
        gnt_vld = (state_q == S_IDLE) && (|pend_q);
        gnt_idx = '0;
`ifdef PART2_SCHED_ROUND_ROBIN_EN
        // Lowest pending index above the last grant, else wrap to the lowest pending index.
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int d = N_DOM - 1; d >= 0; d--) begin
            if (pend_q[d]) begin
                lo_idx = 3'(d);
                if (d > int'(ptr_q)) begin
                    hi_idx = 3'(d);
                    hi_vld = 1'b1;
                end
            end
        end
        gnt_idx = hi_vld ? hi_idx : lo_idx;
`else
        for (int d = N_DOM - 1; d >= 0; d--) begin
            if (pend_q[d]) gnt_idx = 3'(d);
        end
`endif
        gnt_oh = '0;
        g_oh   = '0;
        for (int d = 0; d < N_DOM; d++) begin
            gnt_oh[d] = gnt_vld && (gnt_idx == 3'(d));
            g_oh[d]   = (g_q == 3'(d));
        end
    end

    // Edge tracking, transfer sequencing, response capture and watchdog.
    always_comb begin
        edg = dom_clk_i & ~dom_clk_d_q & dom_en_i;
        acc = (state_q == S_WAIT) && rsp_valid_i && (rsp_dom_i == g_q);
        tmo = (state_q == S_WAIT) && !acc && (cnt_q == CW'(WDOG_MAX - 1));

        state_d = state_q;
        // A domain being granted this cycle is not an overrun even if it edges again.
        pend_d  = (pend_q & ~gnt_oh) | edg;
        ovr_d   = ovr_q | (edg & pend_q & ~gnt_oh);
        frz_d   = frz_q;
        rxv_d   = '0;
        rx_d    = rx_q;
        dat_d   = dat_q;
        g_d     = g_q;
        put_d   = put_q;
        get_d   = get_q;
        wdog_d  = wdog_q;
        cnt_d   = cnt_q;
`ifdef PART2_SCHED_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    g_d   = gnt_idx;
                    put_d = |(put_en_i & gnt_oh);
                    get_d = |(get_en_i & gnt_oh);
                    for (int d = 0; d < N_DOM; d++) begin
                        if (gnt_oh[d]) dat_d = tx_data_i[d*DW +: DW];
                    end
                    frz_d = frz_q | (gnt_oh & {N_DOM{get_d}});
                    // Neither direction enabled: the grant is simply dropped.
                    state_d = put_d ? S_PUT : (get_d ? S_GET : S_IDLE);
`ifdef PART2_SCHED_ROUND_ROBIN_EN
                    ptr_d = gnt_idx;
`endif
                end
            end
            S_PUT: begin
                if (xfer_ack_i) state_d = get_q ? S_GET : S_IDLE;
            end
            S_GET: begin
                if (xfer_ack_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (acc) begin
                    for (int d = 0; d < N_DOM; d++) begin
                        if (g_oh[d]) rx_d[d*DW +: DW] = rsp_data_i;
                    end
                    rxv_d   = g_oh;
                    frz_d   = frz_q & ~g_oh;
                    state_d = S_IDLE;
                end else if (tmo) begin
                    wdog_d  = 1'b1;
                    frz_d   = frz_q & ~g_oh;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            dom_clk_d_q <= '0;
            pend_q      <= '0;
            ovr_q       <= '0;
            frz_q       <= '0;
            rxv_q       <= '0;
            rx_q        <= '0;
            dat_q       <= '0;
            g_q         <= '0;
            put_q       <= 1'b0;
            get_q       <= 1'b0;
            wdog_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef PART2_SCHED_ROUND_ROBIN_EN
            ptr_q       <= 3'(N_DOM - 1);
`endif
        end else begin
            state_q     <= state_d;
            dom_clk_d_q <= dom_clk_i;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            frz_q       <= frz_d;
            rxv_q       <= rxv_d;
            rx_q        <= rx_d;
            dat_q       <= dat_d;
            g_q         <= g_d;
            put_q       <= put_d;
            get_q       <= get_d;
            wdog_q      <= wdog_d;
            cnt_q       <= cnt_d;
`ifdef PART2_SCHED_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign xfer_req_o   = (state_q == S_PUT) || (state_q == S_GET);
    assign xfer_put_o   = (state_q == S_PUT);
    assign xfer_dom_o   = g_q;
    assign xfer_data_o  = dat_q;
    assign rx_valid_o   = rxv_q;
    assign rx_data_o    = rx_q;
    assign freeze_clk_o = frz_q;
    assign overrun_o    = ovr_q;
    assign wdog_err_o   = wdog_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_part_2_fringe_sched.sv
// Bench for part_2_fringe_sched: directed scenarios with literal expectations, then random traffic,
// every cycle compared against a transaction-level model of the scheduler.
module tb_part_2_fringe_sched;
    localparam int N  = 4;
    localparam int DW = 9;
    localparam int WD = 16;
    localparam int TW = N * DW;

    localparam int P_IDLE = 0;
    localparam int P_PUT  = 1;
    localparam int P_GET  = 2;
    localparam int P_WAIT = 3;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  dclk = '0;
    logic [N-1:0]  den  = '0;
    logic [N-1:0]  pen  = '0;
    logic [N-1:0]  gen  = '0;
    logic [TW-1:0] tx   = '0;
    logic          ack  = 1'b0;
    logic          rv   = 1'b0;
    logic [2:0]    rd   = '0;
    logic [DW-1:0] rdat = '0;

    logic          xfer_req;
    logic          xfer_put;
    logic [2:0]    xfer_dom;
    logic [DW-1:0] xfer_data;
    logic [N-1:0]  rx_valid;
    logic [TW-1:0] rx_data;
    logic [N-1:0]  freeze;
    logic [N-1:0]  overrun;
    logic          wdog_err;
    logic          busy;

    part_2_fringe_sched #(.N_DOM(N), .DW(DW), .WDOG_MAX(WD)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .dom_clk_i    (dclk),
        .dom_en_i     (den),
        .put_en_i     (pen),
        .get_en_i     (gen),
        .tx_data_i    (tx),
        .xfer_req_o   (xfer_req),
        .xfer_put_o   (xfer_put),
        .xfer_dom_o   (xfer_dom),
        .xfer_data_o  (xfer_data),
        .xfer_ack_i   (ack),
        .rsp_valid_i  (rv),
        .rsp_dom_i    (rd),
        .rsp_data_i   (rdat),
        .rx_valid_o   (rx_valid),
        .rx_data_o    (rx_data),
        .freeze_clk_o (freeze),
        .overrun_o    (overrun),
        .wdog_err_o   (wdog_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: one service record plus pending/sticky bookkeeping.
    bit [N-1:0]  m_prev, m_pend, m_ovr, m_frz, m_rxv;
    bit [DW-1:0] m_rx [N];
    bit [DW-1:0] m_data;
    bit          m_wdog, m_put, m_get;
    int          ph, m_g, m_last, m_wc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_ovr = '0; m_frz = '0; m_rxv = '0;
        for (int d = 0; d < N; d++) m_rx[d] = '0;
        m_data = '0; m_wdog = 1'b0; m_put = 1'b0; m_get = 1'b0;
        ph = P_IDLE; m_g = 0; m_last = N - 1; m_wc = 0;
    endtask

    function automatic int pick();
`ifdef PART2_SCHED_ROUND_ROBIN_EN
        for (int i = 1; i <= N; i++) begin
            if (m_pend[(m_last + i) % N]) return (m_last + i) % N;
        end
`else
        for (int d = 0; d < N; d++) begin
            if (m_pend[d]) return d;
        end
`endif
        return -1;
    endfunction

    task automatic model_step();
        bit [N-1:0] edg;
        bit [N-1:0] np;
        int gs;
        if (!rstn) begin
            model_reset();
            return;
        end
        edg    = dclk & ~m_prev & den;
        m_prev = dclk;
        m_rxv  = '0;
        gs     = (ph == P_IDLE) ? pick() : -1;
        np     = m_pend;
        for (int d = 0; d < N; d++) begin
            if (edg[d] && m_pend[d] && d != gs) m_ovr[d] = 1'b1;
            if (d == gs) np[d] = 1'b0;
            if (edg[d]) np[d] = 1'b1;
        end
        case (ph)
            P_IDLE: if (gs >= 0) begin
                m_g = gs; m_last = gs;
                m_put = pen[gs]; m_get = gen[gs];
                m_data = tx[gs*DW +: DW];
                if (m_get) m_frz[gs] = 1'b1;
                ph = m_put ? P_PUT : (m_get ? P_GET : P_IDLE);
            end
            P_PUT: if (ack) ph = m_get ? P_GET : P_IDLE;
            P_GET: if (ack) begin ph = P_WAIT; m_wc = 0; end
            default: begin
                if (rv && int'(rd) == m_g) begin
                    m_rx[m_g] = rdat; m_rxv[m_g] = 1'b1; m_frz[m_g] = 1'b0; ph = P_IDLE;
                end else begin
                    m_wc++;
                    if (m_wc == WD) begin
                        m_wdog = 1'b1; m_frz[m_g] = 1'b0; ph = P_IDLE;
                    end
                end
            end
        endcase
        m_pend = np;
    endtask

    function automatic logic [TW-1:0] m_rx_vec();
        logic [TW-1:0] v;
        v = '0;
        for (int d = 0; d < N; d++) v[d*DW +: DW] = m_rx[d];
        return v;
    endfunction

    // One clock: advance, then compare every output with the model away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("xfer_req",  64'(xfer_req),  64'(ph == P_PUT || ph == P_GET));
        chk("xfer_put",  64'(xfer_put),  64'(ph == P_PUT));
        chk("xfer_dom",  64'(xfer_dom),  64'(m_g));
        chk("xfer_data", 64'(xfer_data), 64'(m_data));
        chk("rx_valid",  64'(rx_valid),  64'(m_rxv));
        chk("rx_data",   64'(rx_data),   64'(m_rx_vec()));
        chk("freeze",    64'(freeze),    64'(m_frz));
        chk("overrun",   64'(overrun),   64'(m_ovr));
        chk("wdog_err",  64'(wdog_err),  64'(m_wdog));
        chk("busy",      64'(busy),      64'(ph != P_IDLE));
    endtask

    task automatic edge_on(input logic [N-1:0] m);
        dclk = m;
        tick();
        dclk = '0;
    endtask

    initial begin
        int k;
        int cnt2;
        logic [2:0] order [$];

        model_reset();
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_req",  64'(xfer_req), 64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_frz",  64'(freeze),   64'd0);
        rstn = 1'b1;
        den  = '1;

        // Domain 0, put then get.
        pen = 4'b0001; gen = 4'b0001; tx[0 +: DW] = 9'h0AB;
        edge_on(4'b0001);
        chk("t1_req_T1", 64'(xfer_req), 64'd0);
        tick();
        chk("t1_req_T2", 64'(xfer_req),  64'd1);
        chk("t1_put",    64'(xfer_put),  64'd1);
        chk("t1_data",   64'(xfer_data), 64'h0AB);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t1_get_req", 64'(xfer_req), 64'd1);
        chk("t1_get_dir", 64'(xfer_put), 64'd0);
        chk("t1_frz_get", 64'(freeze[0]), 64'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        rv = 1'b1; rd = 3'd0; rdat = 9'h1A5; tick(); rv = 1'b0;
        chk("t1_rx_data",  64'(rx_data[8:0]), 64'h1A5);
        chk("t1_rx_valid", 64'(rx_valid),     64'h1);
        chk("t1_frz_rel",  64'(freeze[0]),    64'd0);
        tick();
        chk("t1_rxv_pulse", 64'(rx_valid), 64'd0);

        // Domain 1, put only.
        pen = 4'b0010; gen = 4'b0000; tx[DW +: DW] = 9'h155;
        edge_on(4'b0010);
        tick();
        chk("t2_put",  64'(xfer_put),  64'd1);
        chk("t2_dom",  64'(xfer_dom),  64'd1);
        chk("t2_data", 64'(xfer_data), 64'h155);
        chk("t2_frz",  64'(freeze),    64'd0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t2_idle", 64'(busy), 64'd0);

        // Make domain 2 the last grant, then edge 0,2,3 together.
        pen = 4'b0100; tx[2*DW +: DW] = 9'h0C3;
        edge_on(4'b0100);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        pen = 4'b1101;
        edge_on(4'b1101);
        ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (xfer_req) order.push_back(xfer_dom);
        end
        ack = 1'b0;
        chk("t3_count", 64'(order.size()), 64'd3);
        while (order.size() < 3) order.push_back(3'd7);
`ifdef PART2_SCHED_ROUND_ROBIN_EN
        chk("t3_ord0", 64'(order[0]), 64'd3);
        chk("t3_ord1", 64'(order[1]), 64'd0);
        chk("t3_ord2", 64'(order[2]), 64'd2);
`else
        chk("t3_ord0", 64'(order[0]), 64'd0);
        chk("t3_ord1", 64'(order[1]), 64'd2);
        chk("t3_ord2", 64'(order[2]), 64'd3);
`endif

        // Domain 0 get-only: wrong-domain response, then watchdog timeout.
        pen = 4'b0000; gen = 4'b0001;
        edge_on(4'b0001);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        rv = 1'b1; rd = 3'd1; rdat = 9'h055; tick(); rv = 1'b0;
        chk("t4_busy",  64'(busy),      64'd1);
        chk("t4_frz",   64'(freeze[0]), 64'd1);
        chk("t4_rxv",   64'(rx_valid),  64'd0);
        pen = 4'b1000; gen = 4'b0000;
        edge_on(4'b1000);
        k = 2;
        while (!wdog_err && k < 40) begin
            tick();
            k++;
        end
        chk("t5_wdog_cycles", 64'(k), 64'd16);
        chk("t5_wdog",        64'(wdog_err),  64'd1);
        chk("t5_frz_rel",     64'(freeze[0]), 64'd0);
        tick();
        chk("t5_next_req", 64'(xfer_req), 64'd1);
        chk("t5_next_dom", 64'(xfer_dom), 64'd3);
        ack = 1'b1; tick(); ack = 1'b0;

        // Overrun: two edges on domain 2 while domain 0 holds the channel.
        pen = 4'b0101; gen = 4'b0000;
        edge_on(4'b0001);
        tick();
        edge_on(4'b0100);
        tick();
        edge_on(4'b0100);
        chk("t6_overrun", 64'(overrun[2]), 64'd1);
        ack = 1'b1;
        cnt2 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (xfer_req && xfer_dom == 3'd2) cnt2++;
        end
        ack = 1'b0;
        chk("t6_single_service", 64'(cnt2), 64'd1);

        // Reset in the middle of a get.
        pen = 4'b0000; gen = 4'b0010;
        edge_on(4'b0010);
        tick();
        chk("t7_in_get", 64'(xfer_req), 64'd1);
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk("t7_req",  64'(xfer_req), 64'd0);
        chk("t7_frz",  64'(freeze),   64'd0);
        chk("t7_ovr",  64'(overrun),  64'd0);
        chk("t7_wdog", 64'(wdog_err), 64'd0);
        chk("t7_rx",   64'(rx_data),  64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            dclk = dclk ^ N'($urandom & $urandom);
            den  = ($urandom_range(0, 7) != 0) ? '1 : N'($urandom);
            pen  = N'($urandom);
            gen  = N'($urandom);
            tx   = TW'({$urandom, $urandom});
            ack  = ($urandom_range(0, 2) == 0);
            rv   = ($urandom_range(0, 9) < 3);
            rd   = 3'($urandom_range(0, 4));
            rdat = DW'($urandom);
            rstn = ($urandom_range(0, 699) != 0);
            tick();
        end
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
